snake_step_writer: RTL

- Upstream write sequencer for the snake game-state register bank. It drives that bank's single write port: index, value, enable.
- It has two jobs: board initialisation, and one-step snake-1 movement on a 10x10 wrap-around grid.
- It reads back the current board and head/length values from the bank's output bus and issues one register write per cycle.

---
 rtl/snake_step_writer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_step_writer.sv
// Write sequencer for the snake register bank: board initialisation and
// single-step snake-1 movement on a wrap-around grid, one bank write per cycle.
module snake_step_writer #(
  parameter int          GRID_W     = 10,
  parameter int          GRID_H     = 10,
  parameter logic [31:0] START_POS  = 32'd45,
  parameter logic [31:0] START_LEN  = 32'd3,
  parameter logic [1:0]  SNAKE_CODE = 2'd1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         init_req,
  input  logic         step_req,
  input  logic [1:0]   dir,
  input  logic         grow,
  input  logic [6:0]   tail_pos,
  input  logic [199:0] board_in,
  input  logic [31:0]  head_pos_in,
  input  logic [31:0]  length_in,
  output logic [31:0]  wr_index,
  output logic [31:0]  wr_value,
  output logic         wr_enable,
  output logic         busy,
  output logic         done,
  output logic         collision
);

  typedef enum logic [2:0] {
    IDLE, INIT_CLR, INIT_SET, STEP_CALC, STEP_CELL, STEP_POS, STEP_TAIL, DONE
  } state_t;

  localparam logic [6:0]  LAST_CLR = 7'd108;
  localparam logic [31:0] MAX_CELL = 32'(GRID_W * GRID_H - 1);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic        grow_q, grow_d;
  logic [6:0]  tail_q, tail_d;
  logic [31:0] len_q, len_d;
  logic [6:0]  np_q, np_d;
  logic [31:0] idx_q, idx_d, val_q, val_d;
  logic        en_q, en_d, busy_q, busy_d, done_q, done_d, coll_q, coll_d;

  // Next head cell, computed from the live head position during STEP_CALC
  logic [6:0] hp, row, col, nrow, ncol, np_c;
  logic       blocked;

  always_comb begin
    hp   = head_pos_in[6:0];
    row  = hp / 7'(GRID_W);
    col  = hp % 7'(GRID_W);
    nrow = row;
    ncol = col;
    case (dir_q)
      2'd0:    nrow = (row == 7'd0) ? 7'(GRID_H - 1) : row - 7'd1;
      2'd1:    ncol = (col == 7'(GRID_W - 1)) ? 7'd0 : col + 7'd1;
      2'd2:    nrow = (row == 7'(GRID_H - 1)) ? 7'd0 : row + 7'd1;
      default: ncol = (col == 7'd0) ? 7'(GRID_W - 1) : col - 7'd1;
    endcase
    np_c    = 7'(int'(nrow) * GRID_W + int'(ncol));
    blocked = (head_pos_in > MAX_CELL) || (board_in[{np_c, 1'b0} +: 2] != 2'b00);
  end

  // Outputs are computed for the state being entered, so each register
  // reflects the bus contents of the state it is in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    grow_d  = grow_q;
    tail_d  = tail_q;
    len_d   = len_q;
    np_d    = np_q;
    idx_d   = idx_q;
    val_d   = val_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    coll_d  = coll_q;
    case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d = INIT_CLR;
          cnt_d   = 7'd0;
          idx_d   = 32'd0;
          val_d   = 32'd0;
          en_d    = 1'b1;
          coll_d  = 1'b0;
        end else if (step_req) begin
          state_d = STEP_CALC;
          dir_d   = dir;
          grow_d  = grow;
          tail_d  = tail_pos;
        end
      end
      INIT_CLR: begin
        en_d = 1'b1;
        if (cnt_q == LAST_CLR) begin
          state_d = INIT_SET;
          cnt_d   = 7'd0;
          idx_d   = 32'd100;
          val_d   = START_POS;
        end else begin
          cnt_d = cnt_q + 7'd1;
          idx_d = 32'(cnt_q + 7'd1);
          val_d = 32'd0;
        end
      end
      INIT_SET: begin
        case (cnt_q)
          7'd0: begin
            idx_d = 32'd102; val_d = START_LEN; en_d = 1'b1; cnt_d = 7'd1;
          end
          7'd1: begin
            idx_d = 32'd104; val_d = 32'd1; en_d = 1'b1; cnt_d = 7'd2;
          end
          default: begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        endcase
      end
      STEP_CALC: begin
        len_d = length_in;
        np_d  = np_c;
        if (blocked) begin
          coll_d  = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = STEP_CELL;
          idx_d   = 32'(np_c);
          val_d   = 32'(SNAKE_CODE);
          en_d    = 1'b1;
        end
      end
      STEP_CELL: begin
        state_d = STEP_POS;
        idx_d   = 32'd100;
        val_d   = 32'(np_q);
        en_d    = 1'b1;
      end
      STEP_POS: begin
        state_d = STEP_TAIL;
        en_d    = 1'b1;
        if (grow_q) begin
          idx_d = 32'd102;
          val_d = len_q + 32'd1;
        end else begin
          idx_d = 32'(tail_q);
          val_d = 32'd0;
        end
      end
      STEP_TAIL: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      grow_q  <= 1'b0;
      tail_q  <= '0;
      len_q   <= '0;
      np_q    <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      grow_q  <= grow_d;
      tail_q  <= tail_d;
      len_q   <= len_d;
      np_q    <= np_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
    end
  end

  assign wr_index  = idx_q;
  assign wr_value  = val_q;
  assign wr_enable = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = coll_q;

endmodule
